div_ratio_ctrl: RTL
===================

Name: div_ratio_ctrl

Overview:
Run-time controller for the clock-divider datapath. It holds the active divide ratio and accepts new ratios over a valid/ready handshake. New ratios take effect only at a period boundary, so the divided output never glitches or produces a runt pulse. The block sits between a config master (CSR/FSM) and downstream logic that consumes the divided enable/clock and a per-period tick.

Parameters:
CNT_W, 8, width of the divide ratio and the internal counter; legal ratios are 2..2^CNT_W-1.
DEFAULT_DIV, 2, ratio loaded at reset; must be >= 2.

Ports:
clk  input  1  system clock.
rst  input  1  reset; asynchronous, active-high.
en  input  1  run request; 1 = generate output, 0 = stop at the end of the current period.
cfg_valid  input  1  new ratio offered.
cfg_div  input  CNT_W  offered ratio.
cfg_ready  output  1  1 = no pending ratio; a transfer completes when cfg_valid & cfg_ready.
cfg_err  output  1  one-cycle pulse: the accepted ratio was < 2 and was discarded.
cur_div  output  CNT_W  ratio currently in effect.
running  output  1  1 in RUN or DRAIN.
clk_out  output  1  registered divided output.
tick  output  1  registered one-cycle pulse on the first cycle of every output period.

Behaviour:
- Reset (async): state=IDLE, cnt=0, cur_div=DEFAULT_DIV, pending=0, cfg_ready=1, cfg_err=0, clk_out=0, tick=0, running=0. Asserting reset mid-run clears everything immediately. There is no drain on reset.
- States: IDLE, RUN, DRAIN.
- cnt_next: 0 on entry to RUN; otherwise wraps 0..cur_div-1 (cnt==cur_div-1 -> 0, else cnt+1).
- Boundary condition: state RUN/DRAIN and cnt==cur_div-1.
- clk_out is a flop with D = (state_next!=IDLE) & (cnt_next < div_next>>1).
  - Duty cycle: div=2 gives 1H/1L; div=3 gives 1H/2L; div=5 gives 2H/3L.
- tick is a flop with D = (state_next!=IDLE) & (cnt_next==0).
- IDLE -> RUN when en=1. The first cycle after the en sample has cnt=0, clk_out=1, tick=1.
- RUN -> DRAIN when en=0 and not at boundary. RUN -> IDLE when en=0 at boundary.
- DRAIN continues counting.
  - DRAIN -> IDLE at boundary with en=0.
  - DRAIN -> RUN whenever en=1, with no gap and cnt unbroken.
- In IDLE: cnt held at 0, clk_out=0, tick=0.
- Config handshake:
  - On accept with cfg_div>=2: pend_div<=cfg_div, pending<=1, cfg_ready<=0 next cycle.
  - On accept with cfg_div<2: pending unchanged, cfg_err=1 in the next cycle, cfg_ready stays 1.
- Apply point:
  - In IDLE, pending applies on the next edge: cur_div<=pend_div, pending<=0.
  - In RUN/DRAIN, pending applies at the boundary cycle, so the new period starts with the new ratio (div_next=pend_div).
  - pending and cfg_ready return to 0/1 on that same edge.
- Simultaneous accept and boundary: the just-accepted value is not applied at this boundary; it applies at the next one.
- Simultaneous en=1 in IDLE with pending: the new ratio is used for the very first period.
- Width: all compares are unsigned CNT_W-bit; no overflow occurs because cnt < cur_div <= 2^CNT_W-1.

Decomposition:
- Shared package div_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - MIN_DIV=2;
  - the default CNT_W.
- One natural sub-module: div_counter. It contains the cnt register, the wrap logic and the clk_out/tick output flops, driven by run_next and div_next from the control FSM. The FSM and config handshake stay in div_ratio_ctrl.

Test Plan:
1. Reset, then check idle defaults -> cur_div=2, cfg_ready=1, clk_out=0, tick=0, running=0; with en=0 for 10 cycles, clk_out stays 0.
2. en=1, DEFAULT_DIV=2, 10 ns clk -> clk_out toggles 1,0,1,0 (20 ns period); tick on every cycle with clk_out=1; running=1.
3. Running at div=4, write cfg_div=5 when cnt=1 -> cfg_ready low next cycle; current period finishes as 2H/2L; then 2H/3L repeating; cur_div=5 from the boundary; cfg_ready=1 again.
4. Write cfg_div=1, then cfg_div=0 -> cfg_err pulses once per write; cur_div and output unchanged; cfg_ready never drops.
5. div=6, drop en at cnt=2 -> DRAIN; output completes 3H/3L, then IDLE with clk_out=0. Repeat, re-raising en at cnt=4 -> no gap; tick at the expected cnt=0.
6. Assert rst mid-period with a pending ratio -> all outputs at reset values immediately; pending discarded; cur_div=DEFAULT_DIV.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package div_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/div_counter.sv
// Period counter with registered divided output and period-start tick.
// The control FSM supplies the next run state and the ratio for the next cycle.
module div_counter
  import div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_next,
  input  logic             start,
  input  logic [CNT_W-1:0] cur_div,
  input  logic [CNT_W-1:0] div_next,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             clk_d;
  logic             tick_d;

  assign wrap = (cnt == (cur_div - ONE));

  // A fresh start or an idle cycle restarts the period at zero.
  always_comb begin
    cnt_next = '0;
    if (run_next && !start && !wrap) begin
      cnt_next = cnt + ONE;
    end
    clk_d  = run_next & (cnt_next < (div_next >> 1));
    tick_d = run_next & (cnt_next == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      clk_out <= clk_d;
      tick    <= tick_d;
    end
  end

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divide-ratio controller: run/drain FSM plus a one-deep ratio buffer that is
// applied only at a period boundary so the divided output never glitches.
module div_ratio_ctrl
  import div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             running,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(DEFAULT_DIV);

  // Handshake: a ratio transfers on any edge where cfg_valid & cfg_ready;
  // cfg_ready is low exactly while a legal ratio waits to be applied.

  state_t           state;
  state_t           state_next;
  logic             pending;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] div_next;
  logic             wrap;
  logic             boundary;
  logic             apply;
  logic             accept;

  assign cfg_ready = ~pending;
  assign running   = (state != IDLE);
  assign accept    = cfg_valid & cfg_ready;
  assign boundary  = (state != IDLE) & wrap;
  assign apply     = pending & ((state == IDLE) | boundary);
  assign div_next  = apply ? pend_div : cur_div;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = boundary ? IDLE : DRAIN;
      DRAIN: begin
        if (en)            state_next = RUN;
        else if (boundary) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      pend_div <= RST_D;
      cur_div  <= RST_D;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_next;
      cfg_err <= accept & (cfg_div < MIN_D);
      // Apply and accept never coincide: accept requires no pending ratio.
      if (apply) begin
        cur_div <= pend_div;
        pending <= 1'b0;
      end else if (accept && (cfg_div >= MIN_D)) begin
        pend_div <= cfg_div;
        pending  <= 1'b1;
      end
    end
  end

  div_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .run_next (state_next != IDLE),
    .start    (state == IDLE),
    .cur_div  (cur_div),
    .div_next (div_next),
    .wrap     (wrap),
    .clk_out  (clk_out),
    .tick     (tick)
  );

endmodule
